// File: rtl/ysyx_22040750_axi_mem_slave_pkg.sv
// Shared types and constants for the AXI memory responder: FSM encoding,
// response codes, the only supported beat size and the burst error check.
package ysyx_22040750_axi_mem_slave_pkg;

    typedef enum logic [4:0] {
        S_IDLE     = 5'b00001,
        S_RD_FETCH = 5'b00010,
        S_RD_DATA  = 5'b00100,
        S_WR_DATA  = 5'b01000,
        S_WR_RESP  = 5'b10000
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] BEAT_SIZE   = 3'b011;

    // A burst is rejected when it starts outside the window, uses an unsupported
    // beat size or is longer than the responder is willing to serve.
    function automatic logic burst_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] span,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [7:0]  max_len
    );
        return (addr < base) || ((addr - base) >= span) ||
               (size != BEAT_SIZE) || (len > max_len);
    endfunction

endpackage

// File: rtl/ysyx_22040750_sram_1rw_bmask.sv
// Single-port synchronous 64-bit RAM with per-byte write mask; a read returns
// the addressed word one cycle later and the output holds until the next read.
module ysyx_22040750_sram_1rw_bmask #(
    parameter int WORDS = 1024,
    localparam int AW   = $clog2(WORDS)
) (
    input  logic          I_clk,
    input  logic          I_en,
    input  logic          I_we,
    input  logic [AW-1:0] I_addr,
    input  logic [7:0]    I_wmask,
    input  logic [63:0]   I_wdata,
    output logic [63:0]   O_rdata
);

    logic [63:0] mem_q [WORDS];

    // NOTE: the array and the read register have no reset; memory contents must
    // survive a reset and a reset network on every word would not map to RAM.
    always_ff @(posedge I_clk) begin
        if (I_en) begin
            if (I_we) begin
                for (int i = 0; i < 8; i++) begin
                    if (I_wmask[i]) mem_q[I_addr][8*i +: 8] <= I_wdata[8*i +: 8];
                end
            end else begin
                O_rdata <= mem_q[I_addr];
            end
        end
    end

endmodule

// File: rtl/ysyx_22040750_axi_mem_slave.sv
// AXI4-subset memory responder: INCR read/write bursts of 8-byte beats, one
// transaction at a time. Define AXI_SLAVE_RAND_DELAY_EN for LFSR-driven stalls.
module ysyx_22040750_axi_mem_slave
    import ysyx_22040750_axi_mem_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          MAX_LEN   = 7
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [31:0] I_mem_araddr,
    input  logic        I_mem_arvalid,
    input  logic [7:0]  I_mem_arlen,
    input  logic [2:0]  I_mem_arsize,
    output logic        O_mem_arready,
    output logic [63:0] O_mem_rdata,
    output logic [1:0]  O_mem_rresp,
    output logic        O_mem_rvalid,
    output logic        O_mem_rlast,
    input  logic        I_mem_rready,
    input  logic [31:0] I_mem_awaddr,
    input  logic        I_mem_awvalid,
    input  logic [7:0]  I_mem_awlen,
    input  logic [2:0]  I_mem_awsize,
    output logic        O_mem_awready,
    input  logic [63:0] I_mem_wdata,
    input  logic [7:0]  I_mem_wstrb,
    input  logic        I_mem_wvalid,
    input  logic        I_mem_wlast,
    output logic        O_mem_wready,
    output logic [1:0]  O_mem_bresp,
    output logic        O_mem_bvalid,
    input  logic        I_mem_bready
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN      = 32'(MEM_WORDS) << 3;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    state_t             state_q, state_d;
    logic [7:0]         beat_q, len_q;
    logic               err_q, wlast_err_q;
    logic [IDX_W-1:0]   base_idx_q, ar_idx, aw_idx;
    logic               ar_hs, aw_hs, r_hs, w_hs, last_beat, stall_zero;
    logic               sram_en, sram_we;
    logic [IDX_W-1:0]   sram_addr;
    logic [63:0]        sram_q;

    assign O_mem_arready = (state_q == S_IDLE);
    assign O_mem_awready = (state_q == S_IDLE) && !I_mem_arvalid;
    assign O_mem_rvalid  = (state_q == S_RD_DATA) && stall_zero;
    assign O_mem_wready  = (state_q == S_WR_DATA) && stall_zero;
    assign O_mem_bvalid  = (state_q == S_WR_RESP);

    assign ar_hs     = I_mem_arvalid && O_mem_arready;
    assign aw_hs     = I_mem_awvalid && O_mem_awready;
    assign r_hs      = O_mem_rvalid && I_mem_rready;
    assign w_hs      = I_mem_wvalid && O_mem_wready;
    assign last_beat = (beat_q == len_q);

    // Word index wraps modulo the RAM depth; addr[2:0] is ignored.
    assign ar_idx    = IDX_W'((I_mem_araddr - BASE_ADDR) >> 3);
    assign aw_idx    = IDX_W'((I_mem_awaddr - BASE_ADDR) >> 3);
    assign sram_addr = base_idx_q + IDX_W'(beat_q);

    // Error bursts return zero data; rdata is stable because the RAM is only
    // re-read in RD_FETCH.
    assign O_mem_rdata = ((state_q == S_RD_DATA) && !err_q) ? sram_q : 64'd0;
    assign O_mem_rresp = ((state_q == S_RD_DATA) && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign O_mem_rlast = (state_q == S_RD_DATA) && last_beat;
    assign O_mem_bresp = ((state_q == S_WR_RESP) && (err_q || wlast_err_q)) ?
                         RESP_SLVERR : RESP_OKAY;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        sram_en = 1'b0;
        sram_we = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ar_hs)      state_d = S_RD_FETCH;
                else if (aw_hs) state_d = S_WR_DATA;
            end
            S_RD_FETCH: begin
                sram_en = 1'b1;
                state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (r_hs) state_d = last_beat ? S_IDLE : S_RD_FETCH;
            end
            S_WR_DATA: begin
                sram_we = 1'b1;
                sram_en = w_hs && !err_q;
                if (w_hs && last_beat) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (I_mem_bready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            wlast_err_q <= 1'b0;
            base_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            if (ar_hs) begin
                len_q       <= I_mem_arlen;
                err_q       <= burst_err(I_mem_araddr, BASE_ADDR, SPAN, I_mem_arsize,
                                         I_mem_arlen, MAX_LEN_B);
                base_idx_q  <= ar_idx;
                beat_q      <= '0;
                wlast_err_q <= 1'b0;
            end else if (aw_hs) begin
                len_q       <= I_mem_awlen;
                err_q       <= burst_err(I_mem_awaddr, BASE_ADDR, SPAN, I_mem_awsize,
                                         I_mem_awlen, MAX_LEN_B);
                base_idx_q  <= aw_idx;
                beat_q      <= '0;
                wlast_err_q <= 1'b0;
            end
            if (r_hs && !last_beat) beat_q <= beat_q + 8'd1;
            if (w_hs) begin
                if (I_mem_wlast != last_beat) wlast_err_q <= 1'b1;
                if (!last_beat) beat_q <= beat_q + 8'd1;
            end
        end
    end

`ifdef AXI_SLAVE_RAND_DELAY_EN
    logic [15:0] lfsr_q;
    logic [1:0]  stall_q;

    // A fresh 0-3 cycle stall is drawn before each read beat and each write beat.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            lfsr_q  <= 16'hACE1;
            stall_q <= '0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            if ((state_q == S_RD_FETCH) || aw_hs || w_hs) stall_q <= lfsr_q[1:0];
            else if (stall_q != 2'd0)                     stall_q <= stall_q - 2'd1;
        end
    end

    assign stall_zero = (stall_q == 2'd0);
`else
    assign stall_zero = 1'b1;
`endif

    ysyx_22040750_sram_1rw_bmask #(
        .WORDS (MEM_WORDS)
    ) u_sram (
        .I_clk   (I_clk),
        .I_en    (sram_en),
        .I_we    (sram_we),
        .I_addr  (sram_addr),
        .I_wmask (I_mem_wstrb),
        .I_wdata (I_mem_wdata),
        .O_rdata (sram_q)
    );

endmodule
